darkroom_sensor_arbiter: RTL and testbench
==========================================

DARKROOM_SENSOR_ARBITER -- requirements
Module: darkroom_sensor_arbiter

Interface
REQ-001 Parameter NUM_SENSORS, default 16: number of sensor decoder requesters.
REQ-002 Parameter FIFO_DEPTH, default 32: entries in the output FIFO (power of two).
REQ-003 clock  in  1  single clock for all logic.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 sensor_valid  in  NUM_SENSORS  per-decoder word available.
REQ-006 sensor_data  in  NUM_SENSORS*32  flattened decoder words; sensor i occupies bits [32i+31:32i].
REQ-007 sensor_ready  out  NUM_SENSORS  one-hot grant; a transfer occurs when valid & ready.
REQ-008 avalon_slave_address  in  2  register select.
REQ-009 avalon_slave_read / avalon_slave_write  in  1 each  Avalon-MM strobes.
REQ-010 avalon_slave_writedata  in  32;  avalon_slave_readdata  out  32;  avalon_slave_waitrequest  out  1.

Function
REQ-011 Register map: 0 = FIFO data (read pops), 1 = status, 2 = enable mask (R/W, bits [NUM_SENSORS-1:0]), 3 = read-only constant NUM_SENSORS.
REQ-012 Status: [5:0] fill count, [16] overflow sticky, [17] empty, [18] full, other bits 0.
REQ-013 Arbitration SHALL be round-robin: search starts at last_grant+1 (mod NUM_SENSORS); first index with sensor_valid & mask is granted.
REQ-014 At most one sensor_ready bit SHALL be high per cycle; sensor_ready is combinational from valid, mask, pointer and registered full flag.
REQ-015 When FIFO full (count == FIFO_DEPTH at cycle start), all sensor_ready SHALL be 0; a pop in the same cycle does not enable a grant until the next cycle.
REQ-016 Masked sensors SHALL never receive ready; a mask write takes effect the cycle after the write.
REQ-017 FIFO entry pushed on transfer = {granted index[3:0], sensor_data[27:0]}; last_grant updates to the granted index only on a transfer.
REQ-018 Overflow sticky SHALL set on any cycle with an enabled valid while full; cleared only by writing 1 to bit 16 at address 1.
REQ-019 Reads: FSM IDLE->RESPOND->IDLE; waitrequest=1 in the first read cycle, 0 in RESPOND with readdata valid; readdata holds last value otherwise.
REQ-020 Read of address 0 pops exactly one entry in the RESPOND cycle; read of empty FIFO returns 0x0000_0000 with no pointer change.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-022 Writes complete in one cycle with waitrequest=0; writes to addresses 0 and 3 ignored; read takes priority if read and write assert together.
REQ-023 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.

Reset
REQ-024 On reset: FIFO empty (count 0), overflow 0, mask all ones, last_grant = NUM_SENSORS-1 (sensor 0 first), FSM IDLE.
REQ-025 Reset outputs: sensor_ready 0, readdata 0, waitrequest 0.
REQ-026 Reset asserted mid-read SHALL abort the read with no pop; FIFO contents discarded.

Structure
REQ-027 Shared package darkroom_pkg holds NUM_SENSORS, FIFO_DEPTH defaults, register address constants, status bit positions.
REQ-028 FIFO SHALL be sub-module darkroom_sync_fifo (push, pop, data, count, full, empty); arbiter, register file and read FSM stay in the top.

Verification
REQ-029 All 16 valid constantly, FIFO never full -> grants in order 0,1,...,15,0; popped entries carry indices 0..15 in sequence.
REQ-030 Sensors 3 and 9 valid, mask=0xFDFF -> only sensor 3 granted; after mask=0xFFFF, 9 granted next cycle after 3.
REQ-031 Fill 32 entries, no reads -> status full=1, count=32, all ready 0, overflow=1; write 0x0001_0000 to addr1 -> overflow 0.
REQ-032 FIFO full, sensor 5 valid, pop addr0 -> no grant in pop cycle, grant to 5 next cycle, count back to 32.
REQ-033 Read addr0 when empty -> waitrequest 1 then 0, readdata 0x0000_0000, count stays 0; read addr3 -> 0x0000_0010.
REQ-034 Reset asserted during RESPOND with 4 entries -> after reset count 0, readdata 0, sensor 0 granted first.

Source files
------------

// File: rtl/darkroom_pkg.sv
// Shared constants and types for the darkroom sensor arbiter and its FIFO.
package darkroom_pkg;
    localparam int DEF_NUM_SENSORS = 16;
    localparam int DEF_FIFO_DEPTH  = 32;
    localparam int DATA_W          = 32;
    localparam int IDX_FIELD_W     = 4;
    localparam int PAYLOAD_W       = 28;

    localparam logic [1:0] REG_FIFO   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_MASK   = 2'd2;
    localparam logic [1:0] REG_NSENS  = 2'd3;

    localparam int STAT_OVF_BIT   = 16;
    localparam int STAT_EMPTY_BIT = 17;
    localparam int STAT_FULL_BIT  = 18;

    typedef enum logic {
        RD_IDLE,
        RD_RESPOND
    } rd_state_t;

    typedef struct packed {
        logic [IDX_FIELD_W-1:0] idx;
        logic [PAYLOAD_W-1:0]   payload;
    } fifo_entry_t;
endpackage

// File: rtl/darkroom_sync_fifo.sv
// Single-clock FIFO with wrapping pointers and an occupancy count one bit wider than the pointers.
module darkroom_sync_fifo #(
    parameter  int DEPTH = 32,
    parameter  int WIDTH = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/darkroom_sensor_arbiter.sv
// Round-robin sensor arbiter feeding a word FIFO that is drained over an Avalon-MM slave.
// Arbiter, register file and read FSM live here; storage is darkroom_sync_fifo.
module darkroom_sensor_arbiter
    import darkroom_pkg::*;
#(
    parameter int NUM_SENSORS = DEF_NUM_SENSORS,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_SENSORS-1:0]        sensor_valid,
    input  logic [NUM_SENSORS*DATA_W-1:0] sensor_data,
    output logic [NUM_SENSORS-1:0]        sensor_ready,
    input  logic [1:0]                    avalon_slave_address,
    input  logic                          avalon_slave_read,
    input  logic                          avalon_slave_write,
    input  logic [DATA_W-1:0]             avalon_slave_writedata,
    output logic [DATA_W-1:0]             avalon_slave_readdata,
    output logic                          avalon_slave_waitrequest
);
    localparam int IDX_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_SENSORS-1:0] mask;
    logic [NUM_SENSORS-1:0] eligible;
    logic [NUM_SENSORS-1:0] grant_vec;
    logic [IDX_W-1:0]       last_grant;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       cand;
    logic                   grant_hit;
    logic                   ovf;

    rd_state_t              rd_state;
    rd_state_t              rd_state_nxt;
    logic                   capture;
    logic                   waitreq;
    logic                   fifo_pop;
    logic                   pop_pending;
    logic                   wr_en;
    logic [DATA_W-1:0]      rd_value;

    fifo_entry_t            push_entry;
    fifo_entry_t            pop_entry;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   unused_inputs;

    assign eligible      = sensor_valid & mask;
    assign wr_en         = avalon_slave_write && !avalon_slave_read;
    assign unused_inputs = ^{avalon_slave_writedata, sensor_data};

    // Search starts one past the last winner; fifo_full is the registered count, so a pop
    // in this cycle cannot open a grant until the next one.
    always_comb begin
        grant_vec = '0;
        grant_idx = '0;
        grant_hit = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_SENSORS; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_SENSORS);
            if (!grant_hit && !fifo_full && eligible[cand]) begin
                grant_hit       = 1'b1;
                grant_idx       = cand;
                grant_vec[cand] = 1'b1;
            end
        end
    end

    assign sensor_ready       = reset ? '0 : grant_vec;
    assign push_entry.idx     = IDX_FIELD_W'(grant_idx);
    assign push_entry.payload = sensor_data[DATA_W*int'(grant_idx) +: PAYLOAD_W];

    darkroom_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (grant_hit),
        .pop       (fifo_pop),
        .push_data (push_entry),
        .pop_data  (pop_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        rd_value = '0;
        case (avalon_slave_address)
            REG_FIFO:   rd_value = fifo_empty ? '0 : pop_entry;
            REG_STATUS: begin
                rd_value[CNT_W-1:0]     = fifo_count;
                rd_value[STAT_OVF_BIT]   = ovf;
                rd_value[STAT_EMPTY_BIT] = fifo_empty;
                rd_value[STAT_FULL_BIT]  = fifo_full;
            end
            REG_MASK:   rd_value[NUM_SENSORS-1:0] = mask;
            REG_NSENS:  rd_value = DATA_W'(NUM_SENSORS);
        endcase
    end

    // Data is snapshotted in the stalled cycle; the pop lands in RESPOND.
    always_comb begin
        rd_state_nxt = rd_state;
        waitreq      = 1'b0;
        capture      = 1'b0;
        fifo_pop     = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (avalon_slave_read) begin
                    waitreq      = 1'b1;
                    capture      = 1'b1;
                    rd_state_nxt = RD_RESPOND;
                end
            end
            RD_RESPOND: begin
                fifo_pop     = pop_pending;
                rd_state_nxt = RD_IDLE;
            end
        endcase
    end

    assign avalon_slave_waitrequest = waitreq && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_state              <= RD_IDLE;
            pop_pending           <= 1'b0;
            avalon_slave_readdata <= '0;
            mask                  <= '1;
            last_grant            <= IDX_W'(NUM_SENSORS - 1);
            ovf                   <= 1'b0;
        end else begin
            rd_state <= rd_state_nxt;
            if (capture) begin
                avalon_slave_readdata <= rd_value;
                pop_pending           <= (avalon_slave_address == REG_FIFO) && !fifo_empty;
            end
            if (grant_hit) last_grant <= grant_idx;
            if (wr_en && avalon_slave_address == REG_MASK)
                mask <= avalon_slave_writedata[NUM_SENSORS-1:0];
            // A fresh overflow wins over a same-cycle clear.
            if (fifo_full && |eligible)
                ovf <= 1'b1;
            else if (wr_en && avalon_slave_address == REG_STATUS && avalon_slave_writedata[STAT_OVF_BIT])
                ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_darkroom_sensor_arbiter.sv
// Bench for darkroom_sensor_arbiter: vector table, directed corner sequences, and random
// traffic checked against a queue-based reference model.
module tb_darkroom_sensor_arbiter;
    localparam int NS    = 16;
    localparam int DEPTH = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic [NS-1:0]   sensor_valid;
    logic [NS*32-1:0] sensor_data;
    logic [NS-1:0]   sensor_ready;
    logic [1:0]      avalon_slave_address;
    logic            avalon_slave_read;
    logic            avalon_slave_write;
    logic [31:0]     avalon_slave_writedata;
    logic [31:0]     avalon_slave_readdata;
    logic            avalon_slave_waitrequest;

    darkroom_sensor_arbiter #(.NUM_SENSORS(NS), .FIFO_DEPTH(DEPTH)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .sensor_valid             (sensor_valid),
        .sensor_data              (sensor_data),
        .sensor_ready             (sensor_ready),
        .avalon_slave_address     (avalon_slave_address),
        .avalon_slave_read        (avalon_slave_read),
        .avalon_slave_write       (avalon_slave_write),
        .avalon_slave_writedata   (avalon_slave_writedata),
        .avalon_slave_readdata    (avalon_slave_readdata),
        .avalon_slave_waitrequest (avalon_slave_waitrequest)
    );

    always #5 clock = ~clock;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mq[$];
    int          m_last;
    logic [NS-1:0] m_mask;
    bit          m_ovf;
    logic [31:0] m_rd;
    logic [NS-1:0] seen_ready;
    logic [31:0] seen_rd;

    typedef struct {
        logic [NS-1:0] valid;
        logic [NS-1:0] exp_ready;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", nm, act, exp);
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < NS; i++) sensor_data[i*32 +: 32] = $urandom();
    endtask

    // One clock: check outputs against the model at the falling edge, then advance the model.
    task automatic tick(input bit do_pop, input bit exp_wait);
        bit            full_now;
        logic [NS-1:0] elig;
        logic [NS-1:0] exp_ready;
        int            g;
        @(negedge clock);
        full_now = (mq.size() == DEPTH);
        elig = sensor_valid & m_mask;
        g = -1;
        if (!full_now)
            for (int k = 1; k <= NS; k++)
                if (g < 0 && elig[(m_last + k) % NS]) g = (m_last + k) % NS;
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        seen_ready = sensor_ready;
        seen_rd    = avalon_slave_readdata;
        chk("ready", 32'(sensor_ready), 32'(exp_ready));
        chk("waitrequest", 32'(avalon_slave_waitrequest), 32'(exp_wait));
        chk("readdata", avalon_slave_readdata, m_rd);
        @(posedge clock);
        if (avalon_slave_write && !avalon_slave_read) begin
            if (avalon_slave_address == 2'd1 && avalon_slave_writedata[16]) m_ovf = 1'b0;
            if (avalon_slave_address == 2'd2) m_mask = avalon_slave_writedata[NS-1:0];
        end
        if (full_now && |elig) m_ovf = 1'b1;
        if (do_pop) void'(mq.pop_front());
        if (g >= 0) begin
            mq.push_back({4'(g), sensor_data[g*32 +: 28]});
            m_last = g;
        end
        #1;
    endtask

    task automatic avm_read(input logic [1:0] a, input bit also_write, output logic [31:0] got);
        logic [31:0] e;
        bit          pend;
        case (a)
            2'd0: e = (mq.size() > 0) ? mq[0] : 32'h0;
            2'd1: begin
                e = 32'(mq.size());
                e[16] = m_ovf;
                e[17] = (mq.size() == 0);
                e[18] = (mq.size() == DEPTH);
            end
            2'd2: e = 32'(m_mask);
            default: e = 32'(NS);
        endcase
        pend = (a == 2'd0) && (mq.size() > 0);
        avalon_slave_address = a;
        avalon_slave_read    = 1'b1;
        if (also_write) begin
            avalon_slave_write     = 1'b1;
            avalon_slave_writedata = $urandom();
        end
        tick(1'b0, 1'b1);
        m_rd = e;
        tick(pend, 1'b0);
        got = seen_rd;
        avalon_slave_read  = 1'b0;
        avalon_slave_write = 1'b0;
    endtask

    task automatic avm_write(input logic [1:0] a, input logic [31:0] d);
        avalon_slave_address   = a;
        avalon_slave_write     = 1'b1;
        avalon_slave_writedata = d;
        tick(1'b0, 1'b0);
        avalon_slave_write = 1'b0;
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        sensor_valid       = '0;
        avalon_slave_read  = 1'b0;
        avalon_slave_write = 1'b0;
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("rst_ready", 32'(sensor_ready), 32'h0);
        chk("rst_waitrequest", 32'(avalon_slave_waitrequest), 32'h0);
        chk("rst_readdata", avalon_slave_readdata, 32'h0);
        @(posedge clock);
        #1;
        reset  = 1'b0;
        mq.delete();
        m_last = NS - 1;
        m_mask = '1;
        m_ovf  = 1'b0;
        m_rd   = 32'h0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [31:0] got;
        int          r;
        reset = 1'b1;
        sensor_valid = '0;
        avalon_slave_address = '0;
        avalon_slave_read = 1'b0;
        avalon_slave_write = 1'b0;
        avalon_slave_writedata = '0;
        rand_data();

        // Hand-derived round-robin vectors, starting from reset (last grant = 15).
        tbl[0]  = '{16'hFFFF, 16'h0001};
        tbl[1]  = '{16'hFFFF, 16'h0002};
        tbl[2]  = '{16'h0001, 16'h0001};
        tbl[3]  = '{16'h8000, 16'h8000};
        tbl[4]  = '{16'h8001, 16'h0001};
        tbl[5]  = '{16'h8001, 16'h8000};
        tbl[6]  = '{16'h0000, 16'h0000};
        tbl[7]  = '{16'h0410, 16'h0010};
        tbl[8]  = '{16'h0410, 16'h0400};
        tbl[9]  = '{16'h0410, 16'h0010};
        tbl[10] = '{16'h0020, 16'h0020};
        tbl[11] = '{16'h0000, 16'h0000};
        do_reset();
        foreach (tbl[i]) begin
            sensor_valid = tbl[i].valid;
            rand_data();
            tick(1'b0, 1'b0);
            chk($sformatf("tbl%0d", i), 32'(seen_ready), 32'(tbl[i].exp_ready));
        end
        sensor_valid = '0;
        for (int i = 0; i < 10; i++) avm_read(2'd0, 1'b0, got);

        // All sensors valid: strict 0..15,0 rotation and index order in the popped words.
        do_reset();
        sensor_valid = '1;
        for (int k = 0; k < 17; k++) begin
            rand_data();
            tick(1'b0, 1'b0);
            chk("rr_order", 32'(seen_ready), 32'(1) << (k % NS));
        end
        sensor_valid = '0;
        for (int k = 0; k < 17; k++) begin
            avm_read(2'd0, 1'b0, got);
            chk("pop_index", 32'(got[31:28]), 32'(k % NS));
        end

        // Masked sensor 9 never granted; unmasking lets it win right after 3.
        do_reset();
        avm_write(2'd2, 32'h0000_FDFF);
        sensor_valid = 16'h0208;
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0);
            chk("mask_only3", 32'(seen_ready), 32'h0008);
        end
        avm_write(2'd2, 32'h0000_FFFF);
        chk("mask_write_cycle", 32'(seen_ready), 32'h0008);
        tick(1'b0, 1'b0);
        chk("unmask_9", 32'(seen_ready), 32'h0200);
        sensor_valid = '0;

        // Fill to full, overflow sticky and its clear.
        do_reset();
        sensor_valid = '1;
        for (int k = 0; k < DEPTH; k++) begin
            rand_data();
            tick(1'b0, 1'b0);
        end
        tick(1'b0, 1'b0);
        chk("full_no_ready", 32'(seen_ready), 32'h0);
        avm_read(2'd1, 1'b0, got);
        chk("status_full_ovf", got, 32'h0005_0020);
        sensor_valid = '0;
        avm_write(2'd1, 32'h0001_0000);
        avm_read(2'd1, 1'b0, got);
        chk("status_ovf_clr", got, 32'h0004_0020);

        // Pop while full: no grant in the pop cycle, sensor 5 next cycle.
        sensor_valid = 16'h0020;
        avm_read(2'd0, 1'b0, got);
        chk("pop_cycle_no_grant", 32'(seen_ready), 32'h0);
        tick(1'b0, 1'b0);
        chk("grant_after_pop", 32'(seen_ready), 32'h0020);
        sensor_valid = '0;
        avm_read(2'd1, 1'b0, got);
        chk("refilled", got & 32'h0004_003F, 32'h0004_0020);

        // Empty-FIFO read and constant registers.
        do_reset();
        avm_read(2'd0, 1'b0, got);
        chk("empty_read", got, 32'h0);
        avm_read(2'd1, 1'b0, got);
        chk("empty_status", got, 32'h0002_0000);
        avm_read(2'd3, 1'b0, got);
        chk("nsens", got, 32'h0000_0010);
        avm_read(2'd2, 1'b0, got);
        chk("mask_rst", got, 32'h0000_FFFF);

        // Reset during RESPOND aborts the pop and discards the FIFO.
        sensor_valid = 16'h000F;
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b0);
        sensor_valid = '0;
        avalon_slave_address = 2'd0;
        avalon_slave_read = 1'b1;
        tick(1'b0, 1'b1);
        do_reset();
        avm_read(2'd1, 1'b0, got);
        chk("abort_count0", got, 32'h0002_0000);
        sensor_valid = '1;
        tick(1'b0, 1'b0);
        chk("abort_first0", 32'(seen_ready), 32'h0001);
        sensor_valid = '0;

        // Random traffic against the model, alternating drain-heavy and fill-heavy phases.
        do_reset();
        for (int it = 0; it < 800; it++) begin
            if ((it / 100) % 2 == 0)
                sensor_valid = ($urandom_range(0, 3) == 0) ? NS'($urandom()) : '0;
            else
                sensor_valid = NS'($urandom() & $urandom());
            rand_data();
            r = $urandom_range(0, 99);
            if (r < 30)
                avm_read(($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3)),
                         $urandom_range(0, 9) == 0, got);
            else if (r < 34) avm_write(2'd2, $urandom() | 32'h0000_F0F0);
            else if (r < 37) avm_write(2'd1, $urandom());
            else if (r < 39) avm_write($urandom_range(0, 1) ? 2'd0 : 2'd3, $urandom());
            else tick(1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
